// File: rtl/fft_pkg.sv
// Shared definitions for the FFT result readout: FSM encoding, sample width and bit reversal.
package fft_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int sample_w(input int i_bits, input int f_bits);
        return i_bits + f_bits;
    endfunction

    // Reverses the low 'bits' bits of v; upper bits of the result are zero.
    function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < bits) r[b] = v[bits-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_fifo2.sv
// Two-entry FIFO holding returned samples; head is presented combinationally from storage.
module sample_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [DW-1:0] o_data,
    output logic          o_empty,
    output logic [1:0]    o_count
);

    logic [DW-1:0] r_mem [2];
    logic          r_wptr;
    logic          r_rptr;
    logic [1:0]    r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/fft_readout.sv
// Streams one N-point FFT result out of an external RAM pair in index order, with backpressure.
module fft_readout
    import fft_pkg::*;
#(
    parameter int N      = 16,
    parameter int I      = 8,
    parameter int F      = 8,
    parameter int BITREV = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_bank,
    output logic                 o_rd_en,
    output logic [$clog2(N)-1:0] o_rd_addr,
    output logic                 o_bank_sel,
    input  logic [I+F-1:0]       i_rd_re,
    input  logic [I+F-1:0]       i_rd_im,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [I+F-1:0]       o_re,
    output logic [I+F-1:0]       o_im,
    output logic [$clog2(N)-1:0] o_index,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int W  = sample_w(I, F);
    localparam int AW = $clog2(N);
    localparam int DW = 2*W + AW + 1;
    localparam logic [AW-1:0] K_LAST = AW'(N-1);

    state_t        r_state;
    logic [AW-1:0] r_k;
    logic [AW-1:0] r_addr_hold;
    logic [AW-1:0] r_fl_idx;
    logic          r_inflight;
    logic          r_bank;

    logic [31:0]   w_rev;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_head;
    logic [DW-1:0] w_push_data;
    logic          w_empty;
    logic [1:0]    w_count;
    logic [2:0]    w_occ;
    logic          w_pop;
    logic          w_rd_en;
    logic          w_h_last;

    assign w_rev  = bit_reverse(32'(r_k), AW);
    assign w_addr = (BITREV != 0) ? w_rev[AW-1:0] : r_k;

    // Issue only if the sample can be guaranteed a FIFO slot when it returns next cycle.
    assign w_pop   = !w_empty && i_ready;
    assign w_occ   = {1'b0, w_count} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_rd_en = (r_state == S_READ) && (w_occ < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_addr_hold <= '0;
            r_fl_idx    <= '0;
            r_inflight  <= 1'b0;
            r_bank      <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_fl_idx    <= r_k;
                r_addr_hold <= w_addr;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_READ;
                        r_k     <= '0;
                        r_bank  <= i_bank;
                    end
                end
                S_READ: begin
                    if (w_rd_en) begin
                        if (r_k == K_LAST) r_state <= S_DRAIN;
                        else               r_k     <= r_k + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_h_last) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // RAM data is tagged with the index it was issued for, so order is independent of BITREV.
    assign w_push_data = {i_rd_re, i_rd_im, r_fl_idx, (r_fl_idx == K_LAST)};

    sample_fifo2 #(.DW(DW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign {o_re, o_im, o_index, w_h_last} = w_head;
    assign o_last     = w_h_last;
    assign o_valid    = !w_empty;
    assign o_rd_en    = w_rd_en;
    assign o_rd_addr  = w_rd_en ? w_addr : r_addr_hold;
    assign o_bank_sel = r_bank;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);

endmodule

// File: doc/fft_readout.md
FFT_READOUT -- requirements
Module: fft_readout

Interface
REQ-001 Parameter N, 16, transform length (power of two, >=4).
REQ-002 Parameter I, 8, integer bits of each fixed-point component.
REQ-003 Parameter F, 8, fractional bits; sample width W = I+F.
REQ-004 Parameter BITREV, 0, 0 = RAM read address equals output index k; 1 = RAM read address equals bit-reverse(k) over log2(N) bits.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 i_start  input  1  one-cycle pulse; requests readout of one N-point result.
REQ-008 i_bank  input  1  result location: 0 = RAM1, 1 = RAM2; sampled with i_start.
REQ-009 o_rd_en  output  1  read enable to the selected RAM re/im pair.
REQ-010 o_rd_addr  output  log2(N)  read address, shared by re and im.
REQ-011 o_bank_sel  output  1  latched i_bank; steers RAM read-data mux.
REQ-012 i_rd_re, i_rd_im  input  W each  RAM read data, valid exactly one cycle after o_rd_en.
REQ-013 o_valid  output  1  output sample valid.
REQ-014 i_ready  input  1  sink accepts; handshake = o_valid & i_ready.
REQ-015 o_re, o_im  output  W each  output sample, two's complement.
REQ-016 o_index  output  log2(N)  frequency bin k of current sample.
REQ-017 o_last  output  1  high with o_valid on k = N-1.
REQ-018 o_busy  output  1  high from accepted start until o_done.
REQ-019 o_done  output  1  one-cycle pulse after final handshake.

Function
REQ-020 States SHALL be IDLE, READ, DRAIN, DONE; IDLE->READ on i_start; READ->DRAIN after read of k = N-1 issued; DRAIN->DONE on handshake with o_last; DONE->IDLE unconditionally next cycle.
REQ-021 o_done SHALL be high only in DONE; o_busy high in READ, DRAIN and DONE.
REQ-022 i_start outside IDLE SHALL be ignored; i_bank latched only on accepted start.
REQ-023 Read counter k SHALL run 0..N-1, incrementing once per issued read, no wrap within one readout; cleared to 0 on entering READ.
REQ-024 Returned data SHALL be captured into a 2-entry FIFO of {re, im, index, last}; o_valid = FIFO non-empty; outputs from FIFO head.
REQ-025 A read SHALL issue in READ only when (fifo_count + inflight - pop) < 2, pop = current-cycle handshake; FIFO never overflows, no sample lost or duplicated.
REQ-026 First o_rd_en SHALL assert the cycle after accepted i_start; first o_valid two cycles after first o_rd_en.
REQ-027 With i_ready held high, throughput SHALL be one sample per cycle; N samples complete in N+2 cycles after first o_rd_en.
REQ-028 While o_valid & !i_ready, o_re, o_im, o_index, o_last SHALL hold stable.
REQ-029 o_rd_en SHALL be 0 in IDLE, DRAIN, DONE; o_rd_addr holds last value when o_rd_en = 0.
REQ-030 Samples SHALL emerge in index order 0..N-1 regardless of BITREV.

Reset
REQ-031 On rst: state IDLE, k = 0, FIFO empty, inflight = 0, o_bank_sel = 0; all outputs 0.
REQ-032 rst mid-readout SHALL abort immediately; in-flight RAM data discarded; no o_done generated.

Structure
REQ-033 Shared package fft_pkg SHALL hold state encoding constants, width helper W = I+F and bit-reverse function.
REQ-034 FIFO SHALL be sub-module sample_fifo2 (2-entry, parameter width, count output).
REQ-035 Implementation SHALL contain no multipliers and no RAM instance.

Verification
REQ-036 N=8, BITREV=0, i_ready=1, pulse i_start: o_rd_addr 0..7 on consecutive cycles, o_valid from cycle 3, indices 0..7, o_last on 7, o_done at cycle 11.
REQ-037 N=8, BITREV=1: o_rd_addr sequence 0,4,2,6,1,5,3,7; o_index still 0..7 with matching RAM model data.
REQ-038 i_ready low for 5 cycles after 2 handshakes: at most 2 samples buffered, o_rd_en stalls, outputs stable, all 8 samples delivered in order.
REQ-039 i_bank=1 start, second i_start mid-READ with i_bank=0: o_bank_sel stays 1, exactly 8 samples, one o_done.
REQ-040 rst asserted at k=4 mid-stream: all outputs 0 next edge, no o_done; fresh start then delivers full 0..7 sequence.
